instruction_message_scroller: RTL and testbench

- Upstream feeder for the 8-digit seven-segment instruction display. Produces the 40-bit packed `instruction` word that display consumes.
- Accepts a message of up to MAX_CHARS 5-bit character codes. Messages of 8 characters or fewer are shown statically, left-justified. Longer messages scroll right-to-left, one character per STEP_CYCLES clocks.
- Driven by the ATM control FSM, e.g. prompts such as "INSERT CARD" or "ENTER PIN".

---
 rtl/instruction_message_scroller.sv | 115 +++++++++++
 tb/tb_instruction_message_scroller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_message_scroller.sv
// Feeds the 8-digit seven-segment instruction display: short messages are shown statically, longer ones scroll left.
// Optional macro SCROLL_LOOP_EN makes long messages scroll continuously with a blank separator.
module instruction_message_scroller #(
  parameter int MAX_CHARS   = 16,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [5*MAX_CHARS-1:0]   msg,
  input  logic [4:0]               msg_len,
  output logic [39:0]              instruction,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_SCROLL = 1'b1;

  logic                   state;
  logic [5*MAX_CHARS-1:0] msg_buf;
  logic [4:0]             len;
  logic [4:0]             idx;
  logic [CNT_W-1:0]       cnt;

  logic [4:0]  len_c;
  logic [39:0] first8;
  logic [4:0]  cur_char;
  logic [4:0]  ins_char;
  logic        step_hit;

  always_comb begin
    len_c = (msg_len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : msg_len;

    // Char 0 lands in the leftmost digit; digits past len stay blank.
    first8 = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (5'(i) < len_c)
        first8[5*(7-i) +: 5] = msg[5*i +: 5];
    end

    cur_char = '0;
    for (int unsigned i = 0; i < MAX_CHARS; i++) begin
      if (idx == 5'(i))
        cur_char = msg_buf[5*i +: 5];
    end

`ifdef SCROLL_LOOP_EN
    ins_char = (idx == len) ? 5'd0 : cur_char;
`else
    ins_char = cur_char;
`endif

    step_hit = (cnt == CNT_W'(STEP_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      msg_buf     <= '0;
      len         <= '0;
      idx         <= '0;
      cnt         <= '0;
      instruction <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        instruction <= '0;
        busy        <= 1'b0;
        idx         <= '0;
        cnt         <= '0;
      end else if (start) begin
        msg_buf     <= msg;
        len         <= len_c;
        instruction <= first8;
        cnt         <= '0;
        if (len_c > 5'd8) begin
          idx   <= 5'd8;
          busy  <= 1'b1;
          state <= S_SCROLL;
        end else begin
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
      end else if (state == S_SCROLL) begin
        if (step_hit) begin
          cnt         <= '0;
          instruction <= {instruction[34:0], ins_char};
`ifdef SCROLL_LOOP_EN
          // idx == len is the blank separator slot before wrapping to char 0.
          idx <= (idx == len) ? 5'd0 : idx + 5'd1;
`else
          idx <= idx + 5'd1;
          if (idx == len - 5'd1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_message_scroller.sv
// Scoreboard bench for instruction_message_scroller: a window-over-message model predicts each cycle's outputs.
module tb_instruction_message_scroller;

  localparam int MAXC = 16;
  localparam int STEP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [5*MAXC-1:0] msg = '0;
  logic [4:0]      msg_len = '0;
  logic [39:0]     instruction;
  logic            busy;
  logic            done;

  instruction_message_scroller #(.MAX_CHARS(MAXC), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .msg(msg), .msg_len(msg_len),
    .instruction(instruction), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: either blank, or a message shown n edges after it was started.
  bit m_active = 1'b0;
  int m_chars[MAXC];
  int m_len = 0;
  int m_n = 0;

  logic [41:0] exp_q[$];

  function automatic int seq_char(int i);
    int j = i;
`ifdef SCROLL_LOOP_EN
    if (m_len > 8) j = i % (m_len + 1);
`endif
    return (j < m_len) ? m_chars[j] : 0;
  endfunction

  function automatic logic [41:0] expect_now();
    logic [39:0] d = '0;
    logic b = 1'b0, f = 1'b0;
    int k = 0;
    if (m_active) begin
      if (m_len > 8) begin
`ifdef SCROLL_LOOP_EN
        k = m_n / STEP;
        b = 1'b1;
`else
        k = m_n / STEP;
        if (k > m_len - 8) k = m_len - 8;
        b = (m_n < (m_len - 8) * STEP);
        f = (m_n == (m_len - 8) * STEP);
`endif
      end else begin
        f = (m_n == 0);
      end
      for (int j = 0; j < 8; j++) d[39-5*j -: 5] = 5'(seq_char(k + j));
    end
    return {d, b, f};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (abort) begin
      m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_len = (msg_len > 5'(MAXC)) ? MAXC : int'(msg_len);
      for (int i = 0; i < MAXC; i++) m_chars[i] = int'(msg[5*i +: 5]);
      m_n = 0;
    end else if (m_active) begin
      m_n++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    exp_q.push_back(expect_now());
  end

  always @(negedge clk) begin
    logic [41:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({instruction, busy, done} !== e) begin
        errors++;
        $display("FAIL outputs cyc %0d: instruction got %h exp %h, busy got %b exp %b, done got %b exp %b",
                 cyc, instruction, e[41:2], busy, e[1], done, e[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not finish in time (%0d checks, %0d errors)", checks, errors);
    $finish;
  end

  function automatic logic [5*MAXC-1:0] str_msg(string s);
    logic [5*MAXC-1:0] m;
    for (int i = 0; i < MAXC; i++) begin
      if (i < s.len()) m[5*i +: 5] = (s[i] == " ") ? 5'd0 : 5'(s[i] - "A" + 1);
      else             m[5*i +: 5] = 5'($urandom_range(0, 31));
    end
    return m;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic a, input logic [5*MAXC-1:0] m, input logic [4:0] l);
    @(posedge clk); #1;
    start = s; abort = a; msg = m; msg_len = l;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    // Scramble inputs afterwards: only the start-cycle values may matter.
    msg = {$urandom, $urandom, $urandom};
    msg_len = 5'($urandom_range(0, 31));
  endtask

  initial begin
    ticks(3);
    rst_n = 1'b1;
    ticks(2);

    // Static message and hold.
    issue(1'b1, 1'b0, str_msg("ATM"), 5'd3);
    ticks(100);

    // One-shot scroll, then abort mid-scroll.
    issue(1'b1, 1'b0, str_msg("HELLOWORLD"), 5'd10);
    ticks(20);
    issue(1'b1, 1'b0, str_msg("HELLOWORLD"), 5'd10);
    ticks(3);
    issue(1'b0, 1'b1, '0, 5'd0);
    ticks(5);

    // start and abort together from idle.
    issue(1'b1, 1'b1, str_msg("CARD"), 5'd4);
    ticks(5);

    // Restart while scrolling.
    issue(1'b1, 1'b0, str_msg("ENTERPINCODE"), 5'd12);
    ticks(4);
    issue(1'b1, 1'b0, str_msg("CARD"), 5'd4);
    ticks(10);

    // Length clamp and empty message.
    issue(1'b1, 1'b0, str_msg("ABCDEFGHIJKLMNOP"), 5'd20);
    ticks(45);
    issue(1'b1, 1'b0, str_msg(""), 5'd0);
    ticks(5);

    // Long run: loop build keeps scrolling, one-shot build settles.
    issue(1'b1, 1'b0, str_msg("HELLOWORLD"), 5'd10);
    ticks(200);
    issue(1'b0, 1'b1, '0, 5'd0);
    ticks(3);

    // Reset mid-scroll.
    issue(1'b1, 1'b0, str_msg("INSERT CARD"), 5'd11);
    ticks(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instruction, busy, done} !== 42'h0) begin
      errors++;
      $display("FAIL reset: instruction got %h, busy got %b, done got %b, all expected 0",
               instruction, busy, done);
    end
    ticks(2);
    rst_n = 1'b1;
    ticks(10);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [5*MAXC-1:0] m;
      int r;
      m = {$urandom, $urandom, $urandom};
      r = $urandom_range(0, 9);
      issue(1'b1, (r == 0), m, 5'($urandom_range(0, 20)));
      ticks($urandom_range(0, 50));
      if (r == 1) issue(1'b0, 1'b1, '0, 5'd0);
    end

    ticks(3);
    @(negedge clk); #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
